// File: rtl/fp16_acc_if.sv
// Command, operand, result and adder-port bundle for the fp16 accumulation controller.
// The slave modport is the controller's view. The master modport is the view of the environment that drives it.
interface fp16_acc_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic [CNT_W-1:0] cmd_len;
    logic             cmd_ready;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic [15:0]      out_data;
    logic             out_err;
    logic             out_ready;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic             add_start;
    logic             add_done;
    logic [15:0]      add_sum;
    logic             busy;

    modport master (
        output cmd_valid, cmd_len, in_valid, in_data, out_ready, add_done, add_sum,
        input  cmd_ready, in_ready, out_valid, out_data, out_err, add_a, add_b, add_start, busy
    );

    modport slave (
        input  cmd_valid, cmd_len, in_valid, in_data, out_ready, add_done, add_sum,
        output cmd_ready, in_ready, out_valid, out_data, out_err, add_a, add_b, add_start, busy
    );
endinterface

// File: rtl/fp16_acc_ctrl.sv
// Sequences a stream of fp16 terms through the shared multi-cycle adder and returns the running sum.
// This block does no arithmetic. A watchdog aborts the job when the adder never reports completion.
module fp16_acc_ctrl #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic      CLK,
    input  logic      RESETn,
    fp16_acc_if.slave bus
);
    localparam int              WD_W      = $clog2(TIMEOUT + 1) + 1;
    localparam logic [WD_W-1:0] TIMEOUT_V = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE    = WD_W'(1);
    localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] REM_ZERO = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FIRST    = 3'd1,
        S_WAIT_IN  = 3'd2,
        S_LAUNCH   = 3'd3,
        S_WAIT_ADD = 3'd4,
        S_OUT      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [15:0]      add_a_q, add_a_d;
    logic [15:0]      add_b_q, add_b_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic             add_start_q, add_start_d;
    logic             busy_q, busy_d;

    // Next-state and datapath update; rem is tested before every decrement so it never wraps.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    rem_d   = bus.cmd_len;
                    acc_d   = 16'h0000;
                    state_d = (bus.cmd_len == REM_ZERO) ? S_OUT : S_FIRST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FIRST: begin
                if (bus.in_valid) begin
                    acc_d   = bus.in_data;
                    rem_d   = rem_q - REM_ONE;
                    state_d = (rem_q == REM_ONE) ? S_OUT : S_WAIT_IN;
                end else begin
                    state_d = S_FIRST;
                end
            end
            S_WAIT_IN: begin
                if (bus.in_valid) begin
                    add_a_d = acc_q;
                    add_b_d = bus.in_data;
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_WAIT_IN;
                end
            end
            S_LAUNCH: begin
                // The launch cycle counts toward the wait, so the timeout is measured from add_start.
                wdog_d  = WD_ONE;
                state_d = S_WAIT_ADD;
            end
            S_WAIT_ADD: begin
                wdog_d = wdog_q + WD_ONE;
                if (bus.add_done) begin
                    acc_d   = bus.add_sum;
                    rem_d   = rem_q - REM_ONE;
                    state_d = (rem_q == REM_ONE) ? S_OUT : S_WAIT_IN;
                end else if (wdog_d >= TIMEOUT_V) begin
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end else begin
                    state_d = S_WAIT_ADD;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so every port is a flop aligned with state_q.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        in_ready_d  = (state_d == S_FIRST) || (state_d == S_WAIT_IN);
        out_valid_d = (state_d == S_OUT);
        out_data_d  = (state_d == S_OUT) ? acc_d : 16'h0000;
        out_err_d   = (state_d == S_OUT) ? err_d : 1'b0;
        add_start_d = (state_d == S_LAUNCH);
        busy_d      = (state_d != S_IDLE);
    end

    // State, datapath and output registers; reset abandons any job and any add in flight.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            acc_q       <= 16'h0000;
            rem_q       <= REM_ZERO;
            err_q       <= 1'b0;
            wdog_q      <= {WD_W{1'b0}};
            add_a_q     <= 16'h0000;
            add_b_q     <= 16'h0000;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            out_err_q   <= 1'b0;
            add_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            cmd_ready_q <= cmd_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            add_start_q <= add_start_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_start = add_start_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fp16_acc_ctrl.sv
// Directed bench for fp16_acc_ctrl, with a latency-configurable adder model.
// The adder model can also stay silent, or inject stray add_done pulses.
module tb_fp16_acc_ctrl;
    localparam int TMO = 8;

    logic CLK;
    logic RESETn;
    fp16_acc_if #(.CNT_W(8)) bus ();

    fp16_acc_ctrl #(.CNT_W(8), .TIMEOUT(TMO)) dut (.CLK(CLK), .RESETn(RESETn), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_errors = 0;
    int          add_lat  = 0;
    bit          spur_en  = 1'b0;
    int          stale_cnt = 0;
    int          stale_seen = 0;
    int          opnd_bad = 0;
    int          cd = 0;
    logic [15:0] cap_a, cap_b;
    logic [15:0] ops [16];
    logic [15:0] sa [2];
    logic [15:0] sb [2];

    // Stand-in adder: true fp16 sums for the directed pairs, an order-sensitive mix otherwise.
    function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
        else if (a == 16'h4200 && b == 16'h3C00) return 16'h4400;
        else return a + (b ^ 16'h5A5A);
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Adder model, evaluated on the falling edge so add_done is settled before the DUT samples it.
    initial begin
        bus.add_done = 1'b0;
        bus.add_sum  = 16'h0000;
        forever begin
            @(negedge CLK);
            if (!RESETn) begin
                cd = 0;
                bus.add_done = 1'b0;
            end else begin
                bus.add_done = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bus.add_done = 1'b1;
                        bus.add_sum  = model_add(cap_a, cap_b);
                        if (bus.add_a !== cap_a || bus.add_b !== cap_b) opnd_bad++;
                    end
                end else if (stale_cnt != stale_seen) begin
                    stale_seen   = stale_cnt;
                    bus.add_done = 1'b1;
                    bus.add_sum  = 16'hBEEF;
                end else if (spur_en && bus.in_ready && $urandom_range(3) == 0) begin
                    bus.add_done = 1'b1;
                    bus.add_sum  = 16'hDEAD;
                end
                if (bus.add_start && add_lat > 0) begin
                    cd    = add_lat;
                    cap_a = bus.add_a;
                    cap_b = bus.add_b;
                end
            end
        end
    end

    task automatic run_job(input string tag, input int len, input int stall, input int ostall,
                           input int hold, input logic [15:0] exp_sum, input logic exp_err,
                           input int exp_starts, input int exp_lat);
        int cyc = 0, idx = 0, starts = 0, t_ref = -1, t_out = -1, held_n = 0;
        bit done = 1'b0, cmd_taken = 1'b0;
        logic [15:0] got_d = 16'h0000;
        logic        got_e = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'(len);
        while (!done && cyc < 2000) begin
            bus.in_valid = (idx < 16) && ($urandom_range(99) >= stall);
            bus.in_data  = (idx < 16) ? ops[idx] : 16'h0000;
            if (bus.out_valid && held_n < hold) begin
                bus.out_ready = 1'b0;
                held_n++;
            end else begin
                bus.out_ready = ($urandom_range(99) >= ostall);
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                cmd_taken = 1'b1;
                t_ref = cyc;
            end
            if (bus.add_start) begin
                if (starts < 2) begin
                    sa[starts] = bus.add_a;
                    sb[starts] = bus.add_b;
                end
                starts++;
                t_ref = cyc;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid) begin
                if (t_out < 0) begin
                    t_out = cyc;
                    got_d = bus.out_data;
                    got_e = bus.out_err;
                end else begin
                    chk({tag, "_hold_data"}, 64'(bus.out_data), 64'(got_d));
                    chk({tag, "_hold_err"}, 64'(bus.out_err), 64'(got_e));
                end
                if (bus.out_ready) done = 1'b1;
            end
            @(posedge CLK);
            #1;
            cyc++;
            if (cmd_taken) bus.cmd_valid = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk({tag, "_completed"}, 64'(done), 64'd1);
        chk({tag, "_sum"}, 64'(got_d), 64'(exp_sum));
        chk({tag, "_err"}, 64'(got_e), 64'(exp_err));
        chk({tag, "_consumed"}, 64'(idx), 64'(len));
        chk({tag, "_starts"}, 64'(starts), 64'(exp_starts));
        chk({tag, "_opnd_stable"}, 64'(opnd_bad), 64'd0);
        if (exp_lat >= 0) chk({tag, "_latency"}, 64'(t_out - t_ref), 64'(exp_lat));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.cmd_ready, bus.in_ready, bus.out_valid, bus.out_data, bus.out_err,
                    bus.add_a, bus.add_b, bus.add_start, bus.busy});
    endfunction

    initial begin
        logic [15:0] acc;
        int len, k;
        RESETn = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        #1 RESETn = 1'b0;
        #2;
        chk("reset_outputs", all_outs(), 64'd0);
        @(posedge CLK);
        #1 RESETn = 1'b1;
        chk("reset_cycle_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        @(posedge CLK);
        #1;
        chk("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'd1);
        chk("busy_idle", 64'(bus.busy), 64'd0);

        ops[0] = 16'h3C00;
        run_job("len1", 1, 0, 0, 0, 16'h3C00, 1'b0, 0, 2);

        add_lat = 5;
        ops[0] = 16'h3C00; ops[1] = 16'h4000; ops[2] = 16'h3C00; ops[3] = 16'h7777;
        run_job("len3", 3, 0, 0, 0, 16'h4400, 1'b0, 2, 6);
        chk("len3_a0", 64'(sa[0]), 64'h3C00);
        chk("len3_b0", 64'(sb[0]), 64'h4000);
        chk("len3_a1", 64'(sa[1]), 64'h4200);
        chk("len3_b1", 64'(sb[1]), 64'h3C00);

        run_job("len0", 0, 0, 0, 4, 16'h0000, 1'b0, 0, 1);

        add_lat = 0;
        ops[0] = 16'h1234; ops[1] = 16'h5678;
        run_job("timeout", 2, 0, 0, 0, 16'h1234, 1'b1, 1, TMO);

        add_lat = 2;
        ops[0] = 16'h1111; ops[1] = 16'h2222;
        run_job("after_tmo", 2, 0, 0, 0, model_add(16'h1111, 16'h2222), 1'b0, 1, 3);

        spur_en = 1'b1;
        for (int j = 0; j < 6; j++) begin
            len = $urandom_range(6, 1);
            add_lat = $urandom_range(4, 1);
            for (int i = 0; i < 16; i++) ops[i] = 16'($urandom);
            acc = ops[0];
            for (int i = 1; i < len; i++) acc = model_add(acc, ops[i]);
            run_job($sformatf("rand%0d", j), len, 30, 50, 0, acc, 1'b0, len - 1,
                    (len > 1) ? add_lat + 1 : -1);
        end
        spur_en = 1'b0;

        // Reset while an add is outstanding.
        add_lat = 30;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd3;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h3C00;
        k = 0;
        while (!bus.add_start && k < 50) begin
            @(posedge CLK);
            #1;
            bus.cmd_valid = 1'b0;
            k++;
        end
        chk("rst_reached_launch", 64'(bus.add_start), 64'd1);
        bus.in_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("rst_in_wait_add_busy", 64'(bus.busy), 64'd1);
        #3 RESETn = 1'b0;
        #1;
        chk("rst_mid_job_outputs", all_outs(), 64'd0);
        @(posedge CLK);
        #1 RESETn = 1'b1;
        chk("rst_release_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        @(posedge CLK); #1;
        chk("rst_cmd_ready_one", 64'(bus.cmd_ready), 64'd1);
        stale_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
        end
        chk("stale_done_out_valid", 64'(bus.out_valid), 64'd0);
        chk("stale_done_busy", 64'(bus.busy), 64'd0);
        chk("stale_done_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        add_lat = 3;
        ops[0] = 16'h3C00; ops[1] = 16'h4000;
        run_job("post_rst", 2, 0, 0, 0, 16'h4200, 1'b0, 1, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fp16_acc_ctrl.md
# fp16_acc_ctrl

Sequencing controller that accumulates a stream of fp16 operands through the shared multi-cycle fp16 adder in the float MAC datapath. It accepts a command carrying a term count and consumes that many fp16 words from a valid/ready input stream. Each term goes through one start/done add operation with the running sum, and the final sum is presented on a valid/ready output. A watchdog aborts the job if the adder fails to report completion.

## Interface
- CNT_W, 8: width of term count.
- TIMEOUT, 64: max cycles waited for add_done per operation; must be ≥1.
- CLK  in  1  clock, rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_len  in  CNT_W  number of terms to accumulate.
- cmd_ready  out  1  high only in IDLE.
- in_valid  in  1  operand valid.
- in_data  in  16  fp16 operand.
- in_ready  out  1  operand accept.
- out_valid  out  1  result valid.
- out_data  out  16  fp16 sum.
- out_err  out  1  job aborted by timeout; qualified by out_valid.
- out_ out_ready  in  1  result accept.
- add_a, add_b  out  16 each  adder operands, stable from add_start until add_done.
- add_start  out  1  one-cycle adder launch pulse.
- add_done  in  1  adder completion pulse.
- add_sum  in  16  adder result, valid with add_done.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FIRST, WAIT_IN, LAUNCH, WAIT_ADD, OUT. All outputs are registered or decoded from state.
- IDLE: cmd_ready=1.
  - On cmd_valid, latch rem<=cmd_len and acc<=16'h0000.
  - If cmd_len==0, go to OUT; otherwise go to FIRST.
- FIRST: in_ready=1. On in_valid:
  - acc<=in_data and rem<=rem-1. No adder operation is issued.
  - Go to OUT if rem==1, else WAIT_IN.
- WAIT_IN: in_ready=1. On in_valid, add_a<=acc, add_b<=in_data, then go to LAUNCH.
- LAUNCH: add_start=1 for exactly this cycle. Clear the watchdog counter, then go to WAIT_ADD.
- WAIT_ADD: in_ready=0. The watchdog increments each cycle.
  - On add_done: acc<=add_sum and rem<=rem-1. Go to OUT if rem==1, else WAIT_IN.
  - If the watchdog reaches TIMEOUT with no add_done: err<=1, acc unchanged, remaining terms not consumed, go to OUT.
- OUT: out_valid=1, out_data=acc, out_err=err.
  - On out_ready, clear err and go to IDLE.
- add_done outside WAIT_ADD is ignored. add_sum is never sampled outside WAIT_ADD.
- No arithmetic is done in this block. acc is a raw 16-bit fp16 pattern; rem is unsigned CNT_W bits and never wraps, because it is checked before decrement.

## Timing
- Reset values: cmd_ready=0 in the reset cycle and 1 from the first clock after RESETn rises (state=IDLE).
- All other outputs reset to 0: in_ready, out_valid, out_data, out_err, add_a, add_b, add_start, busy. acc, rem, err and the watchdog also reset to 0.
- Asynchronous reset mid-job aborts immediately. Any adder operation in flight is abandoned; the adder shares RESETn.
- Adder handshake: add_start rises 1 cycle after the in_valid&in_ready handshake of the second or later term.
  - add_done is accepted no earlier than the cycle after add_start.
  - Throughput per term = 2 + adder latency cycles, plus any input stall.
- Job latency, len=N≥1, no stalls, adder latency L: cmd accept, then N input handshakes, with out_valid 1 cycle after the last completion.
- len=0: out_valid asserted the cycle after cmd accept, out_data=0x0000.
- Simultaneous add_done and watchdog==TIMEOUT in the same cycle: add_done wins, no error.
- Output held stable while out_valid && !out_ready.

## Test plan
- Reset: assert RESETn=0 mid-WAIT_ADD -> all outputs 0 immediately; cmd_ready=1 one cycle after release; stale add_done ignored.
- cmd_len=1, in_data=0x3C00 -> no add_start pulse; out_data=0x3C00, out_err=0.
- cmd_len=3, inputs 0x3C00, 0x4000, 0x3C00, adder model latency 5 -> exactly 2 add_start pulses.
  - First pulse: add_a=0x3C00, add_b=0x4000. Second: add_a=0x4200, add_b=0x3C00.
  - out_data=0x4400.
- cmd_len=0 -> out_valid the cycle after accept, out_data=0x0000; hold out_ready=0 for 4 cycles -> out_valid and out_data stay stable.
- Timeout, TIMEOUT=8, adder model never responds, cmd_len=2 -> out_valid 8 cycles after add_start with out_err=1 and out_data=first operand; next job runs clean.
- Backpressure: randomize in_valid and out_ready; spurious add_done in WAIT_IN -> sums match reference model; exactly cmd_len input handshakes per job.
